// File: rtl/traffic_led_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_led_ctrl                                           |
// | Description : Per-direction traffic lamp driver. One direction group     |
// |               holds right of way and shows a single movement lamp        |
// |               (left / straight / right / yellow), either steady or       |
// |               blinking. Every other group shows red. Outputs are         |
// |               registered (1-cycle latency from command to lamp).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   NUM_DIR     : number of direction groups (2..8)                        |
// |   TWINKLE_CNT : clock cycles per blink half-period (2..2^24)             |
// |   DIR_W       : width of grant_dir, 2^DIR_W >= NUM_DIR                   |
// | Ports                                                                    |
// |   sys_clk     : in  system clock, rising edge                            |
// |   sys_rst_n   : in  asynchronous active-low reset                        |
// |   grant_dir   : in  [DIR_W-1:0] group holding right of way               |
// |   mov         : in  [2:0] 0 left, 1 straight, 2 right, 3 yellow,         |
// |                 4..7 invalid                                             |
// |   blink       : in  1 = granted lamp flashes, 0 = steady                 |
// |   night_mode  : in  (NIGHT_MODE_EN only) all groups blink yellow         |
// |   led         : out [5*NUM_DIR-1:0] group g at [5g+4:5g],                |
// |                 {left, straight, right, yellow, red}                     |
// |   tog         : out one-cycle pulse on every blink toggle                |
// | Configuration                                                            |
// |   NIGHT_MODE_EN : define to add the night_mode input and the             |
// |                   all-groups flashing-yellow override.                   |
// +--------------------------------------------------------------------------+

module traffic_led_ctrl #(
  parameter int NUM_DIR     = 2,
  parameter int TWINKLE_CNT = 2000,
  parameter int DIR_W       = 3
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [DIR_W-1:0]       grant_dir,
  input  logic [2:0]             mov,
  input  logic                   blink,
`ifdef NIGHT_MODE_EN
  input  logic                   night_mode,
`endif
  output logic [5*NUM_DIR-1:0]   led,
  output logic                   tog
);

  // ------------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------------
  // Counter holds 0..TWINKLE_CNT-1; $clog2 of TWINKLE_CNT is exactly enough
  // bits for that range (TWINKLE_CNT >= 2 so the width is at least 1).
  localparam int                 c_cnt_w    = $clog2(TWINKLE_CNT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TWINKLE_CNT - 1);

  // Command word layout: {night, grant_dir, mov, blink}
  localparam int                 c_cmd_w    = DIR_W + 5;

  // Blink phase state encoding
  localparam logic [0:0]         c_phase_on  = 1'b1;
  localparam logic [0:0]         c_phase_off = 1'b0;

  // Lamp patterns for one group
  localparam logic [4:0]         c_lamp_red    = 5'b00001;
  localparam logic [4:0]         c_lamp_yellow = 5'b00010;
  localparam logic [4:0]         c_lamp_dark   = 5'b00000;

  localparam logic [5*NUM_DIR-1:0] c_led_rst = {NUM_DIR{c_lamp_red}};

  // ------------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------------
  logic                 w_night;
  logic [c_cmd_w-1:0]   w_cmd;
  logic                 w_cmd_chg;
  logic                 w_gd_bad;
  logic                 w_mov_bad;
  logic                 w_invalid;
  logic                 w_blinking;
  logic                 w_wrap;
  logic [4:0]           w_lamp;
  logic [4:0]           w_lit;

  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [0:0]           w_phase_nxt;
  logic                 w_tog_nxt;
  logic [5*NUM_DIR-1:0] w_led_nxt;

  logic [c_cmd_w-1:0]   r_cmd;
  logic                 r_fresh;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [0:0]           r_phase;
  logic [5*NUM_DIR-1:0] r_led;
  logic                 r_tog;

  // ------------------------------------------------------------------------
  // Night-mode source
  // ------------------------------------------------------------------------
`ifdef NIGHT_MODE_EN
  assign w_night = night_mode;
`else
  assign w_night = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Command decode
  // ------------------------------------------------------------------------
  // night_mode is part of the command word so that entering or leaving
  // night mode restarts the blink timing exactly like any other change.
  assign w_cmd = {w_night, grant_dir, mov, blink};

  // r_fresh makes the first command after reset count as a change even if
  // it happens to equal the cleared stored command.
  assign w_cmd_chg = r_fresh | (w_cmd != r_cmd);

  assign w_gd_bad  = ({{(32-DIR_W){1'b0}}, grant_dir} >= 32'(NUM_DIR));
  assign w_mov_bad = mov[2];

  // Night mode overrides the command, so an invalid command is irrelevant
  // while it is active.
  assign w_invalid  = ~w_night & (w_gd_bad | w_mov_bad);
  assign w_blinking = w_night | (~w_invalid & blink);

  assign w_wrap = (r_cnt == c_cnt_last);

  // ------------------------------------------------------------------------
  // Blink counter / phase next-state
  // ------------------------------------------------------------------------
  // Defaults describe the "restart" situation: counter at 0, phase ON, no
  // pulse. That covers a command change (which wins over a coincident wrap),
  // a steady lamp, and an invalid command. Only a held blinking command
  // advances the counter.
  always_comb begin
    w_cnt_nxt   = '0;
    w_phase_nxt = c_phase_on;
    w_tog_nxt   = 1'b0;
    if (!w_cmd_chg && w_blinking) begin
      if (w_wrap) begin
        w_phase_nxt = (r_phase == c_phase_on) ? c_phase_off : c_phase_on;
        w_tog_nxt   = 1'b1;
      end else begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_phase_nxt = r_phase;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Lamp selection
  // ------------------------------------------------------------------------
  // Only mov[1:0] matters here; mov >= 4 is already handled as invalid.
  always_comb begin
    w_lamp = c_lamp_dark;
    if (w_night) begin
      w_lamp = c_lamp_yellow;
    end else begin
      case (mov[1:0])
        2'd0:    w_lamp = 5'b10000;
        2'd1:    w_lamp = 5'b01000;
        2'd2:    w_lamp = 5'b00100;
        default: w_lamp = 5'b00010;
      endcase
    end
  end

  // The phase used for the output is the one being registered this edge,
  // so lamp and phase always update together.
  assign w_lit = (w_phase_nxt == c_phase_on) ? w_lamp : c_lamp_dark;

  generate
    for (genvar g = 0; g < NUM_DIR; g++) begin : g_grp
      localparam logic [DIR_W-1:0] c_grp_id = DIR_W'(g);
      logic w_granted;

      assign w_granted = ~w_invalid & (grant_dir == c_grp_id);

      assign w_led_nxt[5*g +: 5] = w_night   ? w_lit :
                                   w_granted ? w_lit :
                                               c_lamp_red;
    end : g_grp
  endgenerate

  // ------------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd   <= '0;
      r_fresh <= 1'b1;
      r_cnt   <= '0;
      r_phase <= c_phase_on;
      r_led   <= c_led_rst;
      r_tog   <= 1'b0;
    end else begin
      r_cmd   <= w_cmd;
      r_fresh <= 1'b0;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_led   <= w_led_nxt;
      r_tog   <= w_tog_nxt;
    end
  end

  assign led = r_led;
  assign tog = r_tog;

endmodule : traffic_led_ctrl

`default_nettype wire

// File: tb/tb_traffic_led_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_traffic_led_ctrl                                        |
// | Description : Self-checking bench for traffic_led_ctrl (NUM_DIR=2,       |
// |               TWINKLE_CNT=4). Directed scenarios plus random command     |
// |               sequences, compared against a behavioural model that       |
// |               tracks the age of the current command.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_traffic_led_ctrl;

  localparam int NUM_DIR     = 2;
  localparam int TWINKLE_CNT = 4;
  localparam int DIR_W       = 3;

  logic                   sys_clk    = 1'b0;
  logic                   sys_rst_n  = 1'b0;
  logic [DIR_W-1:0]       grant_dir  = '0;
  logic [2:0]             mov        = '0;
  logic                   blink      = 1'b0;
  logic                   night_mode = 1'b0;
  logic [5*NUM_DIR-1:0]   led;
  logic                   tog;

  int num_checks = 0;
  int num_errors = 0;

  // Reference model state: previous command, first-after-reset flag and the
  // number of cycles the current command has been held.
  bit                 m_fresh = 1'b1;
  logic [DIR_W+4:0]   m_prev  = '0;
  int                 m_age   = 0;

  always #5 sys_clk = ~sys_clk;

  traffic_led_ctrl #(
    .NUM_DIR     (NUM_DIR),
    .TWINKLE_CNT (TWINKLE_CNT),
    .DIR_W       (DIR_W)
  ) u_dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .grant_dir  (grant_dir),
    .mov        (mov),
    .blink      (blink),
`ifdef NIGHT_MODE_EN
    .night_mode (night_mode),
`endif
    .led        (led),
    .tog        (tog)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [4:0] lamp_of(input logic [2:0] m);
    case (m)
      3'd0:    return 5'b10000;
      3'd1:    return 5'b01000;
      3'd2:    return 5'b00100;
      default: return 5'b00010;
    endcase
  endfunction

  // Called #1 after a rising edge (reset released); the inputs seen here are
  // the ones sampled at that edge.
  task automatic model_and_check();
    logic [DIR_W+4:0]     cmd;
    bit                   nite, valid, blinking, on, tog_e;
    logic [5*NUM_DIR-1:0] led_e;
`ifdef NIGHT_MODE_EN
    nite = night_mode;
`else
    nite = 1'b0;
`endif
    cmd = {nite, grant_dir, mov, blink};
    if (m_fresh || cmd != m_prev) m_age = 0;
    else                          m_age++;
    m_prev  = cmd;
    m_fresh = 1'b0;

    valid    = (int'(grant_dir) < NUM_DIR) && (int'(mov) < 4);
    blinking = nite || (valid && blink);
    // Phase is ON for the first TWINKLE_CNT cycles of a command, OFF for the
    // next TWINKLE_CNT, and so on; a toggle happens at each multiple.
    on    = !blinking || (((m_age / TWINKLE_CNT) % 2) == 0);
    tog_e = blinking && (m_age > 0) && ((m_age % TWINKLE_CNT) == 0);

    for (int g = 0; g < NUM_DIR; g++) begin
      if (nite)
        led_e[5*g +: 5] = on ? 5'b00010 : 5'b00000;
      else if (valid && int'(grant_dir) == g)
        led_e[5*g +: 5] = on ? lamp_of(mov) : 5'b00000;
      else
        led_e[5*g +: 5] = 5'b00001;
    end
    chk_val("led", 32'(led), 32'(led_e));
    chk_val("tog", 32'(tog), 32'(tog_e));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    model_and_check();
  endtask

  task automatic run_cmd(input int gd, input int mv, input int bl, input int nm, input int hold);
    grant_dir  = DIR_W'(gd);
    mov        = 3'(mv);
    blink      = bl[0];
    night_mode = nm[0];
    repeat (hold) tick();
  endtask

  initial begin
    // Reset held with the first command already presented
    grant_dir = 3'd1; mov = 3'd0; blink = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk_val("rst_led", 32'(led), 32'(10'b0000100001));
    chk_val("rst_tog", 32'(tog), 32'd0);

    // Release away from the edge; first cycle must show left on group 1
    sys_rst_n = 1'b1;
    m_fresh   = 1'b1;
    tick();
    chk_val("first_cmd_led", 32'(led), 32'(10'b1000000001));
    repeat (3) tick();

    // Straight blinking on group 0
    run_cmd(0, 1, 1, 0, 16);
    // Change to right two cycles after a toggle
    run_cmd(1, 1, 1, 0, 6);
    run_cmd(1, 2, 1, 0, 10);
    // Change exactly on a would-be wrap
    run_cmd(0, 3, 1, 0, 8);
    run_cmd(1, 0, 1, 0, 6);
    // Invalid commands
    run_cmd(0, 5, 1, 0, 6);
    run_cmd(3, 1, 1, 0, 6);
    run_cmd(7, 7, 0, 0, 3);

    // Asynchronous reset mid-blink, no clock edge involved
    run_cmd(0, 1, 1, 0, 5);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_val("async_rst_led", 32'(led), 32'(10'b0000100001));
    chk_val("async_rst_tog", 32'(tog), 32'd0);
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      chk_val("rst_hold_led", 32'(led), 32'(10'b0000100001));
    end
    // Same command as before reset must still restart the blink timing
    sys_rst_n = 1'b1;
    m_fresh   = 1'b1;
    repeat (10) tick();

`ifdef NIGHT_MODE_EN
    run_cmd(0, 1, 0, 1, 12);
    run_cmd(0, 1, 0, 0, 4);
`endif

    // Randomized command sequences
    for (int s = 0; s < 200; s++) begin
      int gd, mv, bl, nm, hold;
      gd   = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NUM_DIR - 1) : $urandom_range(NUM_DIR, 7);
      mv   = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7);
      bl   = ($urandom_range(0, 3) != 0) ? 1 : 0;
`ifdef NIGHT_MODE_EN
      nm   = ($urandom_range(0, 7) == 0) ? 1 : 0;
`else
      nm   = 0;
`endif
      hold = ($urandom_range(0, 3) == 0) ? TWINKLE_CNT * $urandom_range(1, 3)
                                         : $urandom_range(1, 12);
      run_cmd(gd, mv, bl, nm, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule : tb_traffic_led_ctrl

`default_nettype wire
